// File: rtl/ata_pio.sv
// rtl/ata_pio.sv - ATA/IDE PIO cycle engine: chip select, IOR/IOW timing, IORDY wait and DTACK.
module ata_pio #(
    parameter logic [7:0] BASE      = 8'hDA,
    parameter int         CS_BIT    = 12,
    parameter int         T_SETUP   = 2,
    parameter int         T_STROBE  = 6,
    parameter int         T_HOLD    = 1,
    parameter int         T_RECOVER = 4,
    parameter int         T_TIMEOUT = 255
) (
    input  logic        CLKCPU,
    input  logic        RESET,
    input  logic        AS,
    input  logic        RW,
    input  logic [23:0] A,
    input  logic        WAIT,
    output logic [1:0]  IDECS,
    output logic        IOR,
    output logic        IOW,
    output logic        DTACK,
    output logic        ACCESS,
    output logic        TIMEOUT
);
    localparam int CW = 10;
    localparam logic [CW-1:0] LD_SETUP   = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_STROBE  = CW'(T_STROBE - 1);
    localparam logic [CW-1:0] LD_HOLD    = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] LD_TIMEOUT = CW'(T_TIMEOUT - 1);
    localparam logic [CW-1:0] LD_RECOVER = CW'(T_RECOVER);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STROBE, S_EXTEND, S_HOLD, S_ACK, S_RECOVER
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          rw_q, rw_n, cs_q, cs_n;
    logic          wait_s1, wait_s2;
    logic          timeout_n, cnt_zero, strobing;
    logic [1:0]    idecs_n;
    logic          ior_n, iow_n, dtack_n;
    logic          addr_unused;

    assign ACCESS      = !(!AS && (A[23:16] == BASE));
    assign cnt_zero    = (cnt == '0);
    assign addr_unused = ^A;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        rw_n      = rw_q;
        cs_n      = cs_q;
        timeout_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (!ACCESS) begin
                    rw_n    = RW;
                    cs_n    = A[CS_BIT];
                    cnt_n   = LD_SETUP;
                    state_n = S_SETUP;
                end
            end
            S_SETUP: begin
                // AS rising mid-cycle aborts into HOLD so chip select hold is still honoured
                if (AS) begin
                    state_n = S_HOLD;
                    cnt_n   = LD_HOLD;
                end else if (cnt_zero) begin
                    state_n = S_STROBE;
                    cnt_n   = LD_STROBE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_STROBE: begin
                if (AS || (cnt_zero && wait_s2)) begin
                    state_n = S_HOLD;
                    cnt_n   = LD_HOLD;
                end else if (cnt_zero) begin
                    state_n = S_EXTEND;
                    cnt_n   = LD_TIMEOUT;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_EXTEND: begin
                if (AS || wait_s2 || cnt_zero) begin
                    state_n   = S_HOLD;
                    cnt_n     = LD_HOLD;
                    timeout_n = !AS && !wait_s2;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_HOLD: begin
                if (!cnt_zero) begin
                    cnt_n = cnt - CW'(1);
                end else if (!AS) begin
                    state_n = S_ACK;
                end else begin
                    state_n = (T_RECOVER == 0) ? S_IDLE : S_RECOVER;
                    cnt_n   = LD_RECOVER;
                end
            end
            S_ACK: begin
                if (AS) begin
                    state_n = (T_RECOVER == 0) ? S_IDLE : S_RECOVER;
                    cnt_n   = LD_RECOVER;
                end
            end
            S_RECOVER: begin
                // leaving on the edge where the count reaches 0 gives exactly T_RECOVER idle clocks
                if (cnt <= CW'(1)) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase

        strobing = (state_n == S_STROBE) || (state_n == S_EXTEND);
        idecs_n  = 2'b11;
        if ((state_n == S_SETUP) || strobing || (state_n == S_HOLD))
            idecs_n = cs_n ? 2'b10 : 2'b01;
        ior_n   = !(strobing && rw_n);
        iow_n   = !(strobing && !rw_n);
        dtack_n = (state_n != S_ACK);
    end

    always_ff @(posedge CLKCPU) begin
        if (RESET) begin
            state   <= S_IDLE;
            cnt     <= '0;
            rw_q    <= 1'b1;
            cs_q    <= 1'b0;
            wait_s1 <= 1'b1;
            wait_s2 <= 1'b1;
            IDECS   <= 2'b11;
            IOR     <= 1'b1;
            IOW     <= 1'b1;
            DTACK   <= 1'b1;
            TIMEOUT <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            rw_q    <= rw_n;
            cs_q    <= cs_n;
            wait_s1 <= WAIT;
            wait_s2 <= wait_s1;
            IDECS   <= idecs_n;
            IOR     <= ior_n;
            IOW     <= iow_n;
            DTACK   <= dtack_n;
            TIMEOUT <= timeout_n;
        end
    end
endmodule

// File: doc/ata_pio.md
# ata_pio

Parametrised ATA/IDE PIO cycle engine that replaces the stubbed `ata` block on TF53x boards. It decodes accesses to the IDE window and drives `IDECS`, `IOR` and `IOW` with programmable setup, strobe, hold and recovery times counted in CPU clocks. It honours drive `IORDY` through `WAIT` with a timeout, and returns an active-low `DTACK` to the bus logic. It sits beside `bus_top` and is clocked by `CLKCPU`.

## Interface
Parameters:
- `BASE`, default 8'hDA: value of `A[23:16]` that selects the IDE window.
- `CS_BIT`, default 12: address bit choosing CS0 (0) or CS1 (1).
- `T_SETUP`, default 2: clocks from chip select valid to strobe assertion; valid range 1..15.
- `T_STROBE`, default 6: minimum clocks of strobe low; valid range 1..63.
- `T_HOLD`, default 1: clocks chip select is held after the strobe rises; valid range 1..15.
- `T_RECOVER`, default 4: idle clocks after `DTACK` release before the next cycle; valid range 0..63.
- `T_TIMEOUT`, default 255: maximum extra strobe clocks while `WAIT` is low; valid range 1..1023.

Ports:
- `CLKCPU` in 1: CPU clock; every flop is clocked on the rising edge.
- `RESET` in 1: reset, synchronous and active-high.
- `AS` in 1: address strobe, active low, synchronous to `CLKCPU`.
- `RW` in 1: 1 = read, 0 = write.
- `A` in 24: CPU address.
- `WAIT` in 1: drive IORDY; 0 = drive requests extension.
- `IDECS` out 2: active-low chip selects, `[1]` = CS0, `[0]` = CS1.
- `IOR` out 1: active-low read strobe.
- `IOW` out 1: active-low write strobe.
- `DTACK` out 1: active-low cycle acknowledge.
- `ACCESS` out 1: active-low combinational window decode, `!AS && A[23:16]==BASE`.
- `TIMEOUT` out 1: active-high, one clock, pulses when an IORDY wait expires.

## Operation
- FSM states are IDLE, SETUP, STROBE, EXTEND, HOLD, ACK, RECOVER. A single down-counter, wide enough for the largest parameter, times every state.
- IDLE:
  - A new cycle starts when `AS`=0 and the decode hits.
  - On start, latch `RW` and `A[CS_BIT]`, drive the matching `IDECS` bit low, load `T_SETUP-1`, and go to SETUP.
- SETUP: count to 0, then go to STROBE. In STROBE, `IOR` is low if the latched `RW`=1, otherwise `IOW` is low. Load `T_STROBE-1` on entry.
- STROBE at count 0:
  - If `WAIT`=1, go to HOLD.
  - If `WAIT`=0, go to EXTEND and load `T_TIMEOUT-1`.
- EXTEND:
  - The strobe stays low.
  - Go to HOLD on the first clock `WAIT`=1.
  - When the count reaches 0 with `WAIT` still 0, pulse `TIMEOUT` and go to HOLD.
- HOLD: the strobe is high and chip select is still low. Load `T_HOLD-1` on entry. At 0, go to ACK.
- ACK:
  - `IDECS` goes to 2'b11 and `DTACK` is driven 0.
  - `DTACK` holds until `AS` is sampled 1.
  - The clock after `AS` is sampled 1, `DTACK` goes to 1 and the FSM enters RECOVER with `T_RECOVER` loaded.
- RECOVER: count to 0, then go to IDLE. If `T_RECOVER`=0, go directly to IDLE. A new `AS` is ignored until the FSM reaches IDLE.
- Abort: if `AS` rises during SETUP, STROBE or EXTEND, go to HOLD on the next clock. The strobe ends immediately, hold time is still honoured, and ACK exits at once because `AS` is high.
- `WAIT` is double-registered before use. The sampled value lags by 2 clocks, and the timeout counts from the registered value.

## Timing
- Reset values: `IDECS`=2'b11, `IOR`=1, `IOW`=1, `DTACK`=1, `TIMEOUT`=0, FSM in IDLE, counter 0. `ACCESS` follows its inputs even during reset.
- `RESET` asserted in any state forces the reset values on the next edge, with no hold phase.
- All outputs are registered except `ACCESS`.
- Latency with `WAIT`=1: `IDECS` low 1 clock after `AS` is sampled.
- The strobe falls `T_SETUP` clocks after `IDECS`.
- The strobe is low exactly `T_STROBE` clocks.
- `DTACK` falls `T_HOLD` clocks after the strobe rises.
- Start to `DTACK`: `1+T_SETUP+T_STROBE+T_HOLD` clocks. With defaults this is 10.
- The maximum strobe width is `T_STROBE+T_TIMEOUT` clocks.
- At most one of `IOR` and `IOW` is low at any time. A strobe is never low while `IDECS`=2'b11.

## Test plan
- Read of 0xDA2000 with `WAIT`=1 and defaults -> `IDECS`=2'b01, `IOR` low for 6 clocks, `DTACK` low 10 clocks after `AS`. `DTACK` releases 1 clock after `AS` rises. The next `AS` is held off for 4 clocks.
- Write of 0xDA1000 -> `IDECS`=2'b10, `IOW` low for 6 clocks, `IOR` stays 1 throughout.
- `WAIT`=0 for 20 clocks of strobe -> the strobe stretches until registered `WAIT`=1 (2-clock lag). `TIMEOUT` stays 0.
- `WAIT` held 0 with `T_TIMEOUT`=8 -> strobe width is 14 clocks, a single `TIMEOUT` pulse, and `DTACK` still asserts.
- `AS` rises in clock 3 of STROBE -> the strobe goes high the next clock, `T_HOLD` is honoured, `DTACK` never asserts, then RECOVER.
- `RESET` pulsed mid-STROBE -> all outputs return to reset values on the next edge. Access to 0xDB0000 -> `ACCESS`=1 and no strobes.
